// File: rtl/status_stack.sv
// Z/N/C/V status register with a LIFO of flag snapshots for nested save/restore.
// Stack misuse (overflow, underflow, simultaneous push/pop) raises a sticky error.
module status_stack #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4,
    localparam int LEVEL_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  status_reset_n,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic                  carry_in,
    input  logic                  overflow_in,
    input  logic                  status_wr,
    input  logic [3:0]            flag_mask,
    input  logic                  flags_load,
    input  logic [3:0]            flags_in,
    input  logic                  status_push,
    input  logic                  status_pop,
    input  logic                  err_clr,
    output logic                  status_Z,
    output logic                  status_N,
    output logic                  status_C,
    output logic                  status_V,
    output logic [LEVEL_W-1:0]    stack_level,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  stack_error
);

    logic [3:0]                   flags_reg;
    logic [3:0]                   flags_next;
    logic [LEVEL_W-1:0]           level_reg;
    logic [LEVEL_W-1:0]           level_next;
    logic                         error_reg;
    logic                         error_next;
    logic [STACK_DEPTH-1:0][3:0]  entry_bus;
    logic [3:0]                   candidate;
    logic [3:0]                   write_value;
    logic [3:0]                   top_entry;
    logic                         full;
    logic                         empty;
    logic                         push_ok;
    logic                         pop_ok;
    logic                         misuse;

    assign full  = (level_reg == LEVEL_W'(STACK_DEPTH));
    assign empty = (level_reg == '0);

    assign push_ok = status_push && !status_pop && !full;
    assign pop_ok  = status_pop && !status_push && !empty;
    assign misuse  = (status_push && status_pop)
                   || (status_push && !status_pop && full)
                   || (status_pop && !status_push && empty);

    // Candidate vector in flag order {V, C, N, Z}.
    assign candidate   = {overflow_in, carry_in, result_in[DATA_WIDTH-1], (result_in == '0)};
    assign write_value = (candidate & flag_mask) | (flags_reg & ~flag_mask);

    always_comb begin
        top_entry = entry_bus[0];
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (level_reg == LEVEL_W'(i + 1)) begin
                top_entry = entry_bus[i];
            end
        end
    end

    always_comb begin
        flags_next = flags_reg;
        level_next = level_reg;
        error_next = error_reg;

        if (pop_ok) begin
            flags_next = top_entry;
        end else if (flags_load) begin
            flags_next = flags_in;
        end else if (status_wr) begin
            flags_next = write_value;
        end

        if (push_ok) begin
            level_next = level_reg + LEVEL_W'(1);
        end else if (pop_ok) begin
            level_next = level_reg - LEVEL_W'(1);
        end

        // A fresh misuse outranks a clear in the same cycle.
        if (misuse) begin
            error_next = 1'b1;
        end else if (err_clr) begin
            error_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!status_reset_n) begin
            flags_reg <= '0;
            level_reg <= '0;
            error_reg <= 1'b0;
        end else begin
            flags_reg <= flags_next;
            level_reg <= level_next;
            error_reg <= error_next;
        end
    end

    generate
        for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
            logic [3:0] slot_reg;

            always_ff @(posedge clock) begin
                if (!status_reset_n) begin
                    slot_reg <= '0;
                end else if (push_ok && (level_reg == LEVEL_W'(gi))) begin
                    slot_reg <= flags_reg;
                end
            end

            assign entry_bus[gi] = slot_reg;
        end
    endgenerate

    assign status_Z    = flags_reg[0];
    assign status_N    = flags_reg[1];
    assign status_C    = flags_reg[2];
    assign status_V    = flags_reg[3];
    assign stack_level = level_reg;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_error = error_reg;

endmodule

// File: tb/tb_status_stack.sv
// Directed bench for status_stack: queue-based reference model checked every cycle,
// plus literal expectations after key steps.
module tb_status_stack;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          status_reset_n = 1'b0;
    logic [DW-1:0] result_in = '0;
    logic          carry_in = 1'b0;
    logic          overflow_in = 1'b0;
    logic          status_wr = 1'b0;
    logic [3:0]    flag_mask = '0;
    logic          flags_load = 1'b0;
    logic [3:0]    flags_in = '0;
    logic          status_push = 1'b0;
    logic          status_pop = 1'b0;
    logic          err_clr = 1'b0;
    logic          status_Z, status_N, status_C, status_V;
    logic [LW-1:0] stack_level;
    logic          stack_full, stack_empty, stack_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_flags = '0;
    logic [3:0] m_stack [$];
    logic       m_err   = 1'b0;
    bit         m_valid = 1'b0;

    status_stack #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .status_reset_n (status_reset_n),
        .result_in      (result_in),
        .carry_in       (carry_in),
        .overflow_in    (overflow_in),
        .status_wr      (status_wr),
        .flag_mask      (flag_mask),
        .flags_load     (flags_load),
        .flags_in       (flags_in),
        .status_push    (status_push),
        .status_pop     (status_pop),
        .err_clr        (err_clr),
        .status_Z       (status_Z),
        .status_N       (status_N),
        .status_C       (status_C),
        .status_V       (status_V),
        .stack_level    (stack_level),
        .stack_full     (stack_full),
        .stack_empty    (stack_empty),
        .stack_error    (stack_error)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] dut_flags();
        return {status_V, status_C, status_N, status_Z};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flags plus a queue of snapshots, updated on each rising edge.
    initial begin
        forever begin
            @(posedge clock);
            if (!status_reset_n) begin
                m_flags = '0;
                m_stack.delete();
                m_err   = 1'b0;
                m_valid = 1'b1;
            end else begin
                logic [3:0] nf;
                logic [3:0] cand;
                bit push_ok, pop_ok, bad;
                push_ok = status_push && !status_pop && (m_stack.size() < DEPTH);
                pop_ok  = status_pop && !status_push && (m_stack.size() > 0);
                bad     = (status_push || status_pop) && !push_ok && !pop_ok;
                cand[0] = (result_in == 0);
                cand[1] = result_in[DW-1];
                cand[2] = carry_in;
                cand[3] = overflow_in;
                nf = m_flags;
                if (flags_load) begin
                    nf = flags_in;
                end else if (status_wr) begin
                    for (int b = 0; b < 4; b++) if (flag_mask[b]) nf[b] = cand[b];
                end
                if (pop_ok) nf = m_stack.pop_back();
                if (push_ok) m_stack.push_back(m_flags);
                if (bad) m_err = 1'b1;
                else if (err_clr) m_err = 1'b0;
                m_flags = nf;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (m_valid) begin
                check("model_flags", {4'h0, dut_flags()}, {4'h0, m_flags});
                check("model_level", 8'(stack_level), 8'(m_stack.size()));
                check("model_full",  {7'h0, stack_full},  {7'h0, (m_stack.size() == DEPTH)});
                check("model_empty", {7'h0, stack_empty}, {7'h0, (m_stack.size() == 0)});
                check("model_error", {7'h0, stack_error}, {7'h0, m_err});
            end
        end
    end

    task automatic step(input logic rn, input logic wr, input logic [3:0] mask,
                        input logic [DW-1:0] res, input logic c, input logic v,
                        input logic ld, input logic [3:0] fin,
                        input logic ps, input logic pp, input logic ec);
        status_reset_n = rn;
        status_wr      = wr;
        flag_mask      = mask;
        result_in      = res;
        carry_in       = c;
        overflow_in    = v;
        flags_load     = ld;
        flags_in       = fin;
        status_push    = ps;
        status_pop     = pp;
        err_clr        = ec;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        step(1, 0, 4'h0, '0, 0, 0, 0, 4'h0, 0, 0, 0);
    endtask

    task automatic push_load(input logic [3:0] fin);
        step(1, 0, 4'h0, '0, 0, 0, 1, fin, 1, 0, 0);
    endtask

    initial begin
        // Reset, also with push asserted to show other inputs are ignored.
        step(0, 1, 4'hF, '0, 1, 1, 1, 4'hF, 1, 0, 0);
        check("rst_flags", {4'h0, dut_flags()}, 8'h00);
        check("rst_level", 8'(stack_level), 8'd0);
        check("rst_empty_full", {6'h0, stack_empty, stack_full}, 8'b10);
        check("rst_error", {7'h0, stack_error}, 8'h0);

        step(1, 1, 4'hF, 16'h0000, 1, 0, 0, 4'h0, 0, 0, 0);
        check("wr_all", {4'h0, dut_flags()}, 8'b0101);

        step(1, 1, 4'b0010, 16'h8000, 0, 1, 0, 4'h0, 0, 0, 0);
        check("wr_mask_n", {4'h0, dut_flags()}, 8'b0111);

        step(1, 0, 4'h0, '0, 0, 0, 1, 4'b1010, 1, 0, 0);
        check("load_push_flags", {4'h0, dut_flags()}, 8'b1010);
        check("load_push_level", 8'(stack_level), 8'd1);

        step(1, 1, 4'hF, 16'h0000, 1, 1, 0, 4'h0, 0, 1, 0);
        check("pop_restore", {4'h0, dut_flags()}, 8'b0111);
        check("pop_level", 8'(stack_level), 8'd0);

        step(1, 1, 4'b0011, 16'h0001, 0, 0, 0, 4'h0, 0, 0, 0);
        check("wr_nonzero", {4'h0, dut_flags()}, 8'b0100);

        step(1, 0, 4'h0, '0, 0, 0, 0, 4'h0, 0, 1, 0);
        check("empty_pop_err", {7'h0, stack_error}, 8'h1);
        check("empty_pop_flags", {4'h0, dut_flags()}, 8'b0100);
        step(1, 0, 4'h0, '0, 0, 0, 0, 4'h0, 0, 0, 1);
        check("clr_err", {7'h0, stack_error}, 8'h0);

        push_load(4'b0001);
        push_load(4'b0010);
        step(1, 0, 4'h0, '0, 0, 0, 0, 4'h0, 1, 1, 0);
        check("pushpop_level", 8'(stack_level), 8'd2);
        check("pushpop_err", {7'h0, stack_error}, 8'h1);
        step(1, 0, 4'h0, '0, 0, 0, 0, 4'h0, 1, 1, 1);
        check("err_wins_clr", {7'h0, stack_error}, 8'h1);
        step(1, 0, 4'h0, '0, 0, 0, 0, 4'h0, 0, 0, 1);

        push_load(4'b0011);
        push_load(4'b1000);
        check("full_level", 8'(stack_level), 8'd4);
        check("full_flag", {7'h0, stack_full}, 8'h1);
        push_load(4'b1111);
        check("overflow_level", 8'(stack_level), 8'd4);
        check("overflow_err", {7'h0, stack_error}, 8'h1);
        check("overflow_flags", {4'h0, dut_flags()}, 8'b1111);
        step(1, 0, 4'h0, '0, 0, 0, 0, 4'h0, 0, 0, 1);
        check("clr_after_full", {7'h0, stack_error}, 8'h0);

        step(1, 0, 4'h0, '0, 0, 0, 0, 4'h0, 0, 1, 0);
        check("lifo_top", {4'h0, dut_flags()}, 8'b0011);
        step(1, 0, 4'h0, '0, 0, 0, 0, 4'h0, 1, 1, 0);

        // Reset pulse that never spans a rising edge must have no effect.
        status_reset_n = 1'b0;
        #2 status_reset_n = 1'b1;
        idle();
        check("glitch_level", 8'(stack_level), 8'd3);
        check("glitch_err", {7'h0, stack_error}, 8'h1);

        step(0, 0, 4'h0, '0, 0, 0, 0, 4'h0, 1, 0, 0);
        check("midrst_flags", {4'h0, dut_flags()}, 8'h00);
        check("midrst_level", 8'(stack_level), 8'd0);
        check("midrst_err", {7'h0, stack_error}, 8'h0);

        step(1, 0, 4'h0, '0, 0, 0, 0, 4'h0, 0, 1, 0);
        check("post_rst_pop_err", {7'h0, stack_error}, 8'h1);

        step(1, 1, 4'hF, 16'hFFFF, 1, 1, 1, 4'b0110, 0, 0, 0);
        check("load_beats_wr", {4'h0, dut_flags()}, 8'b0110);

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
